// File: rtl/message_stream_splitter_if.sv
// Merged-stream input and per-channel output bus of the message stream splitter.
// slave is the splitter's side, master the producer/consumer side.
interface message_stream_splitter_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned N_STREAMS = 4
);
  logic [WIDTH-1:0]           in_data;
  logic                       in_nd;
  logic [WIDTH*N_STREAMS-1:0] out_data;
  logic [N_STREAMS-1:0]       out_nd;
  logic                       error;

  modport master (
    output in_data, in_nd,
    input  out_data, out_nd, error
  );

  modport slave (
    input  in_data, in_nd,
    output out_data, out_nd, error
  );
endinterface

// File: rtl/message_stream_splitter.sv
// Routes each packet (header + LEN payload blocks) of one merged message stream
// to the output stream selected by the header's DEST field; one-cycle registered latency.
module message_stream_splitter #(
  parameter int unsigned N_STREAMS             = 4,
  parameter int unsigned LOG_N_STREAMS         = 2,
  parameter int unsigned WIDTH                 = 32,
  parameter int unsigned MAX_PACKET_LENGTH     = 1024,
  parameter int unsigned LOG_MAX_PACKET_LENGTH = 10
) (
  input logic                     clk,
  input logic                     rst,
  message_stream_splitter_if.slave bus
);

  localparam int unsigned LEN_W  = LOG_MAX_PACKET_LENGTH;
  localparam int unsigned DEST_W = LOG_N_STREAMS;
  localparam int unsigned CMP_W  = LOG_N_STREAMS + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    DROP    = 2'd2
  } state_t;

  state_t                     state;
  logic [LEN_W-1:0]           remaining;
  logic [DEST_W-1:0]          dest;
  logic [WIDTH*N_STREAMS-1:0] out_data_q;
  logic [N_STREAMS-1:0]       out_nd_q;
  logic                       error_q;

  logic              is_header_c;
  logic [LEN_W-1:0]  hdr_len_c;
  logic [DEST_W-1:0] hdr_dest_c;
  logic              dest_ok_c;
  logic              fwd_en_c;
  logic [DEST_W-1:0] fwd_sel_c;

  // Header field decode and forwarding decision for the current input block.
  always_comb begin
    is_header_c = bus.in_data[WIDTH-1];
    hdr_len_c   = bus.in_data[WIDTH-2 -: LEN_W];
    hdr_dest_c  = bus.in_data[WIDTH-2-LEN_W -: DEST_W];
    dest_ok_c   = {1'b0, hdr_dest_c} < CMP_W'(N_STREAMS);
    fwd_en_c    = 1'b0;
    fwd_sel_c   = dest;
    if (bus.in_nd) begin
      if (state == IDLE) begin
        fwd_en_c  = is_header_c && dest_ok_c;
        fwd_sel_c = hdr_dest_c;
      end else if (state == FORWARD) begin
        fwd_en_c  = 1'b1;
      end
    end
  end

  // Packet FSM plus registered outputs; only valid input cycles advance it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= '0;
      dest       <= '0;
      out_data_q <= '0;
      out_nd_q   <= '0;
      error_q    <= 1'b0;
    end else begin
      out_nd_q <= '0;
      for (int unsigned k = 0; k < N_STREAMS; k++) begin
        if (fwd_en_c && (fwd_sel_c == DEST_W'(k))) begin
          out_data_q[k*WIDTH +: WIDTH] <= bus.in_data;
          out_nd_q[k]                  <= 1'b1;
        end
      end
      if (bus.in_nd) begin
        case (state)
          IDLE: begin
            if (!is_header_c) begin
              error_q <= 1'b1;
            end else begin
              if (dest_ok_c) begin
                dest <= hdr_dest_c;
              end else begin
                error_q <= 1'b1;
              end
              if (hdr_len_c != '0) begin
                remaining <= hdr_len_c;
                state     <= dest_ok_c ? FORWARD : DROP;
              end
            end
          end
          FORWARD, DROP: begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.out_data = out_data_q;
  assign bus.out_nd   = out_nd_q;
  assign bus.error    = error_q;

endmodule

// File: tb/tb_message_stream_splitter.sv
// Directed self-checking bench for message_stream_splitter (4-stream and 3-stream builds).
module tb_message_stream_splitter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  message_stream_splitter_if #(.WIDTH(32), .N_STREAMS(4)) bus4 ();
  message_stream_splitter_if #(.WIDTH(32), .N_STREAMS(3)) bus3 ();

  message_stream_splitter #(
    .N_STREAMS(4), .LOG_N_STREAMS(2), .WIDTH(32),
    .MAX_PACKET_LENGTH(1024), .LOG_MAX_PACKET_LENGTH(10)
  ) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  message_stream_splitter #(
    .N_STREAMS(3), .LOG_N_STREAMS(2), .WIDTH(32),
    .MAX_PACKET_LENGTH(1024), .LOG_MAX_PACKET_LENGTH(10)
  ) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  function automatic logic [31:0] hdr(input int unsigned len, input int unsigned dest,
                                      input logic [18:0] tag);
    return {1'b1, 10'(len), 2'(dest), tag};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the chosen bus (0: 4-stream, 1: 3-stream); outputs sampled 1ns after the edge.
  task automatic step(input bit sel3, input logic nd, input logic [31:0] data);
    bus4.in_nd   = sel3 ? 1'b0 : nd;
    bus4.in_data = sel3 ? 32'h0 : data;
    bus3.in_nd   = sel3 ? nd : 1'b0;
    bus3.in_data = sel3 ? data : 32'h0;
    @(posedge clk);
    #1;
  endtask

  logic [127:0] exp4;
  logic [31:0]  w;
  int           good;

  initial begin
    bus4.in_nd = 1'b0; bus4.in_data = '0;
    bus3.in_nd = 1'b0; bus3.in_data = '0;
    exp4 = '0;

    // 1: reset, then mid-packet reset followed by a fresh header
    rst = 1'b1;
    step(0, 1'b0, 32'h0);
    step(0, 1'b0, 32'h0);
    check("rst_out_nd", 128'(bus4.out_nd), 128'h0);
    check("rst_out_data", 128'(bus4.out_data), 128'h0);
    check("rst_error", 128'(bus4.error), 128'h0);
    rst = 1'b0;
    step(0, 1'b1, hdr(3, 2, 19'h00001));
    check("mid_hdr_nd", 128'(bus4.out_nd), 128'h4);
    step(0, 1'b1, 32'h0000_0011);
    check("mid_pay_nd", 128'(bus4.out_nd), 128'h4);
    rst = 1'b1;
    step(0, 1'b0, 32'h0);
    rst = 1'b0;
    check("mid_rst_data", 128'(bus4.out_data), 128'h0);
    w = hdr(0, 1, 19'h0ABCD);
    step(0, 1'b1, w);
    exp4[63:32] = w;
    check("post_rst_nd", 128'(bus4.out_nd), 128'h2);
    check("post_rst_data", bus4.out_data, exp4);
    check("post_rst_err", 128'(bus4.error), 128'h0);

    // 2: LEN=3 DEST=2 at full rate, other slots hold
    w = hdr(3, 2, 19'h11111);
    step(0, 1'b1, w); exp4[95:64] = w;
    check("t2_hdr_nd", 128'(bus4.out_nd), 128'h4);
    check("t2_hdr_data", bus4.out_data, exp4);
    step(0, 1'b1, 32'hA000_0001); exp4[95:64] = 32'hA000_0001;
    check("t2_p0_nd", 128'(bus4.out_nd), 128'h4);
    check("t2_p0_data", bus4.out_data, exp4);
    step(0, 1'b1, 32'hFFFF_0003); exp4[95:64] = 32'hFFFF_0003;
    check("t2_p1_nd", 128'(bus4.out_nd), 128'h4);
    check("t2_p1_data", bus4.out_data, exp4);
    step(0, 1'b1, 32'h0000_0002); exp4[95:64] = 32'h0000_0002;
    check("t2_p2_nd", 128'(bus4.out_nd), 128'h4);
    check("t2_p2_data", bus4.out_data, exp4);
    step(0, 1'b0, 32'hDEAD_BEEF);
    check("t2_gap_nd", 128'(bus4.out_nd), 128'h0);
    check("t2_gap_data", bus4.out_data, exp4);

    // 3: back-to-back packets to different streams with gaps
    w = hdr(0, 1, 19'h00222);
    step(0, 1'b1, w); exp4[63:32] = w;
    check("t3_h1_nd", 128'(bus4.out_nd), 128'h2);
    step(0, 1'b0, 32'h0);
    check("t3_gap1_nd", 128'(bus4.out_nd), 128'h0);
    w = hdr(1, 3, 19'h00333);
    step(0, 1'b1, w); exp4[127:96] = w;
    check("t3_h2_nd", 128'(bus4.out_nd), 128'h8);
    step(0, 1'b0, 32'h0);
    check("t3_gap2_nd", 128'(bus4.out_nd), 128'h0);
    step(0, 1'b1, 32'h1234_5678); exp4[127:96] = 32'h1234_5678;
    check("t3_pay_nd", 128'(bus4.out_nd), 128'h8);
    check("t3_data", bus4.out_data, exp4);
    check("t3_err", 128'(bus4.error), 128'h0);

    // 4: stray payload while IDLE, then a good packet
    step(0, 1'b1, 32'h0000_1234);
    check("t4_stray_nd", 128'(bus4.out_nd), 128'h0);
    check("t4_stray_err", 128'(bus4.error), 128'h1);
    check("t4_stray_data", bus4.out_data, exp4);
    w = hdr(1, 0, 19'h00444);
    step(0, 1'b1, w); exp4[31:0] = w;
    check("t4_hdr_nd", 128'(bus4.out_nd), 128'h1);
    step(0, 1'b1, 32'hCAFE_F00D); exp4[31:0] = 32'hCAFE_F00D;
    check("t4_pay_nd", 128'(bus4.out_nd), 128'h1);
    check("t4_data", bus4.out_data, exp4);
    check("t4_err_sticky", 128'(bus4.error), 128'h1);

    // 5: 3-stream build, out-of-range DEST dropped with its payload
    check("t5_err_init", 128'(bus3.error), 128'h0);
    step(1, 1'b1, hdr(2, 3, 19'h00555));
    check("t5_drop_h_nd", 128'(bus3.out_nd), 128'h0);
    check("t5_drop_err", 128'(bus3.error), 128'h1);
    step(1, 1'b1, hdr(0, 1, 19'h00666));
    check("t5_drop_p0_nd", 128'(bus3.out_nd), 128'h0);
    step(1, 1'b1, 32'h0000_0777);
    check("t5_drop_p1_nd", 128'(bus3.out_nd), 128'h0);
    check("t5_drop_data", 128'(bus3.out_data), 128'h0);
    w = hdr(0, 0, 19'h00888);
    step(1, 1'b1, w);
    check("t5_hdr_nd", 128'(bus3.out_nd), 128'h1);
    check("t5_hdr_data", 128'(bus3.out_data), 128'(w));

    // 6: maximum length packet
    good = 0;
    w = hdr(1023, 1, 19'h00999);
    step(0, 1'b1, w);
    if (bus4.out_nd === 4'b0010 && bus4.out_data[63:32] === w) good++;
    for (int i = 1; i <= 1023; i++) begin
      w = 32'(i) * 32'h0001_0003;
      step(0, 1'b1, w);
      if (bus4.out_nd === 4'b0010 && bus4.out_data[63:32] === w) good++;
    end
    check("t6_count", 128'(good), 128'd1024);
    exp4[63:32] = w;
    check("t6_last_data", bus4.out_data, exp4);
    w = hdr(0, 2, 19'h00AAA);
    step(0, 1'b1, w); exp4[95:64] = w;
    check("t6_next_nd", 128'(bus4.out_nd), 128'h4);
    check("t6_next_data", bus4.out_data, exp4);
    step(0, 1'b0, 32'h0);
    check("t6_idle_nd", 128'(bus4.out_nd), 128'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
